// File: rtl/yoda_cipher_pkg.sv
// Shared definitions for the rotating-key stream cipher: FSM state encoding,
// default widths and the key rotate-left helper.
package yoda_cipher_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_KEY_W      = 32;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Widest key the rotate helper handles; narrower keys sit in the low bits.
  localparam int MAX_KEY_W = 64;
  localparam int MAX_IDX_W = $clog2(MAX_KEY_W);

  typedef enum logic [0:0] {
    NOKEY = 1'b0,
    RUN   = 1'b1
  } cipher_state_e;

  // Rotate the low 'width' bits of key left by 'amt' (amt < width).
  // Bits at and above 'width' come back as zero.
  function automatic logic [MAX_KEY_W-1:0] rotl_key(
    input logic [MAX_KEY_W-1:0] key,
    input int                   width,
    input int                   amt
  );
    logic [MAX_KEY_W-1:0] res;
    int                   src;
    res = '0;
    src = 0;
    for (int i = 0; i < MAX_KEY_W; i++) begin
      if (i < width) begin
        if (i >= amt) begin
          src = i - amt;
        end else begin
          src = i + width - amt;
        end
        res[i] = key[src[MAX_IDX_W-1:0]];
      end else begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cipher_fifo.sv
// Output buffer for the cipher stream: synchronous FIFO with occupancy count.
// A push while full is only taken when a pop happens on the same edge.
module cipher_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s;
  logic             empty_s;
  logic             do_wr_s;
  logic             do_rd_s;

  // Handshake qualification, pointer advance (natural wrap) and count update.
  always_comb begin
    full_s   = (count_q == CNT_W'(DEPTH));
    empty_s  = (count_q == {CNT_W{1'b0}});
    do_rd_s  = rd_en_i && !empty_s;
    do_wr_s  = wr_en_i && (!full_s || do_rd_s);
    wr_ptr_d = do_wr_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = do_rd_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the read port shows zero while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = empty_s;
  assign count_o   = count_q;

endmodule

// File: rtl/rot_cipher_stream.sv
// Rotating-key XOR stream cipher.
// Pipeline: accept edge latches plaintext with the rotated key (stage 1),
// next edge forms the ciphertext (stage 2), next edge pushes it into the
// output FIFO. Input readiness reserves FIFO room for words in flight.
// Optional feature: define ROT_CIPHER_AUTO_ROT_EN to add a per-word counter
// to the requested rotation offset.
module rot_cipher_stream
  import yoda_cipher_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int KEY_W      = DEFAULT_KEY_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [KEY_W-1:0]              key_in,
  input  logic                          key_load,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [$clog2(KEY_W)-1:0]      rot_offset,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          keyed,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int ROT_W = $clog2(KEY_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  cipher_state_e     state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [DATA_W-1:0] s1_key_q, s1_key_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;

  logic              accept_s;
  logic [ROT_W-1:0]  eff_off_s;
  logic [CNT_W:0]    occupancy_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [DATA_W-1:0] fifo_rd_data_s;
  logic              fifo_empty_s;
  logic              out_valid_s;
  logic              pop_s;

  // Mode FSM: the first key load enables the stream; only reset disables it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NOKEY: begin
        if (key_load) begin
          state_d = RUN;
        end else begin
          state_d = NOKEY;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = NOKEY;
    endcase
  end

  // Key register: a new key takes effect for words accepted after this edge.
  always_comb begin
    key_d = key_q;
    if (key_load) begin
      key_d = key_in;
    end else begin
      key_d = key_q;
    end
  end

  // FSM state and key storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NOKEY;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

`ifdef ROT_CIPHER_AUTO_ROT_EN
  logic [ROT_W-1:0] word_cnt_q, word_cnt_d;

  // Per-word rotation counter; restarts whenever a key is programmed.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (key_load) begin
      word_cnt_d = '0;
    end else if (accept_s) begin
      word_cnt_d = word_cnt_q + ROT_W'(1);
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // Word counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  // ROT_W-bit addition wraps modulo KEY_W because KEY_W is a power of two.
  assign eff_off_s = rot_offset + word_cnt_q;
`else
  assign eff_off_s = rot_offset;
`endif

  // Words held anywhere downstream of the input; in_ready keeps this below
  // FIFO_DEPTH so a stage-2 push always finds room.
  assign occupancy_s = {1'b0, fifo_count_s}
                     + {{CNT_W{1'b0}}, s1_valid_q}
                     + {{CNT_W{1'b0}}, s2_valid_q};

  // Input readiness from registered state only.
  always_comb begin
    in_ready = 1'b0;
    if ((state_q == RUN) && (occupancy_s < (CNT_W + 1)'(FIFO_DEPTH))) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  assign accept_s = in_valid && in_ready;

  // Stage 1 captures plaintext and the current key rotated by the effective
  // offset; only the low DATA_W bits of the rotated key are ever used.
  always_comb begin
    s1_valid_d = accept_s;
    s1_data_d  = s1_data_q;
    s1_key_d   = s1_key_q;
    if (accept_s) begin
      s1_data_d = in_data;
      s1_key_d  = DATA_W'(rotl_key(MAX_KEY_W'(key_q), KEY_W, int'(eff_off_s)));
    end else begin
      s1_data_d = s1_data_q;
      s1_key_d  = s1_key_q;
    end
  end

  // Stage 2 forms the ciphertext from the stage-1 word.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_data_d  = s2_data_q;
    if (s1_valid_q) begin
      s2_data_d = s1_data_q ^ s1_key_q;
    end else begin
      s2_data_d = s2_data_q;
    end
  end

  // Pipeline registers; reset drops every in-flight word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_key_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_key_q   <= s1_key_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out_valid_s = !fifo_empty_s;
  assign pop_s       = out_valid_s && out_ready;

  cipher_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (s2_valid_q),
    .wr_data_i (s2_data_q),
    .rd_en_i   (pop_s),
    .rd_data_o (fifo_rd_data_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s)
  );

  assign out_data   = fifo_rd_data_s;
  assign out_valid  = out_valid_s;
  assign fifo_count = fifo_count_s;
  assign keyed      = (state_q == RUN);

endmodule

// File: tb/tb_rot_cipher_stream.sv
// Self-checking bench for rot_cipher_stream (default parameters).
// The reference model keeps a queue of expected ciphertext words stamped
// with their acceptance cycle; a word becomes visible two edges later.
module tb_rot_cipher_stream;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef ROT_CIPHER_AUTO_ROT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [31:0]   key_in;
  logic          key_load;
  logic [DW-1:0] in_data;
  logic [4:0]    rot_offset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          keyed;
  logic [2:0]    fifo_count;

  rot_cipher_stream dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_load   (key_load),
    .in_data    (in_data),
    .rot_offset (rot_offset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .keyed      (keyed),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          e;
  } entry_t;

  int          total = 0;
  int          bad   = 0;
  entry_t      mq[$];
  logic [31:0] obs_log[$];
  logic [31:0] m_key;
  bit          m_keyed;
  int          m_cnt;
  int          cyc;
  bit          m_last_acc;
  int          sent;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] k, input int s);
    if (s == 0) return k;
    return (k << s) | (k >> (32 - s));
  endfunction

  task automatic model_clear();
    mq.delete();
    m_key   = 32'h0;
    m_keyed = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock: compare outputs with the model, clock, then update the model.
  task automatic step();
    int  vis;
    bit  ev, er, acc, pop;
    int  eff;
    vis = 0;
    foreach (mq[i]) if (cyc >= mq[i].e + 2) vis++;
    ev = (vis != 0);
    er = m_keyed && (mq.size() < DEPTH);
    check_eq("in_ready", 64'(in_ready), 64'(er));
    check_eq("out_valid", 64'(out_valid), 64'(ev));
    check_eq("fifo_count", 64'(fifo_count), 64'(vis));
    check_eq("keyed", 64'(keyed), 64'(m_keyed));
    if (ev) check_eq("out_data", 64'(out_data), 64'(mq[0].val));
    if (out_valid && out_ready) obs_log.push_back(out_data);
    acc = in_valid && er && reset;
    pop = ev && out_ready;
    m_last_acc = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      model_clear();
      return;
    end
    if (pop) void'(mq.pop_front());
    if (acc) begin
      eff = (int'(rot_offset) + (AUTO ? m_cnt : 0)) % 32;
      mq.push_back('{val: in_data ^ rotl32(m_key, eff), e: cyc});
      m_last_acc = 1'b1;
    end
    if (key_load) m_cnt = 0;
    else if (acc) m_cnt = (m_cnt + 1) % 32;
    if (key_load) begin
      m_key   = key_in;
      m_keyed = 1'b1;
    end
  endtask

  task automatic load_key(input logic [31:0] k);
    key_in   = k;
    key_load = 1'b1;
    in_valid = 1'b0;
    step();
    key_load = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] off);
    in_data    = d;
    rot_offset = off;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b0; key_in = 32'h0; key_load = 1'b0; in_data = 32'h0;
    rot_offset = 5'd0; in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0; m_last_acc = 1'b0; sent = 0;
    model_clear();

    // Reset state
    #2;
    check_eq("rst_out_data", 64'(out_data), 64'h0);
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    reset = 1'b1;
    idle(2);

    // Words offered before any key are ignored
    in_valid = 1'b1; in_data = 32'h12345678;
    step(); step();
    idle(3);

    // Plain key, zero offset, latency of two edges
    load_key(32'hDEADBEEF);
    send(32'h0, 5'd0);
    idle(1);
    check_eq("lat_not_yet", 64'(out_valid), 64'h0);
    idle(1);
    check_eq("lat_valid", 64'(out_valid), 64'h1);
    check_eq("lat_data", 64'(out_data), 64'hDEADBEEF);
    idle(2);

    // Rotation by 1 and by 31
    obs_log.delete();
    load_key(32'h80000001);
    send(32'hFFFFFFFF, 5'd1);
    load_key(32'h80000001);
    send(32'hFFFFFFFF, 5'd31);
    idle(4);
    check_eq("rot1", 64'(obs_log[0]), 64'hFFFFFFFC);
    check_eq("rot31", 64'(obs_log[1]), 64'h3FFFFFFF);

    // Backpressure: six words offered with out_ready low
    out_ready = 1'b0;
    load_key(32'hA5C3_0F96);
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (sent < 6); in_data = $urandom; rot_offset = 5'($urandom_range(0, 31));
      step();
      if (m_last_acc) sent++;
    end
    check_eq("accepted_at_full", 64'(sent), 64'd4);
    check_eq("ready_at_full", 64'(in_ready), 64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (sent < 6); in_data = $urandom; rot_offset = 5'($urandom_range(0, 31));
      step();
      if (m_last_acc) sent++;
    end
    check_eq("accepted_all", 64'(sent), 64'd6);
    idle(3);

    // Key change on the accept edge: that word keeps the old key
    obs_log.delete();
    load_key(32'h11111111);
    key_in = 32'h0F0F0F0F; key_load = 1'b1;
    send(32'h0, 5'd0);
    key_load = 1'b0;
    send(32'h0, 5'd0);
    idle(4);
    check_eq("old_key_word", 64'(obs_log[0]), 64'h11111111);
    check_eq("new_key_word", 64'(obs_log[1]), 64'h0F0F0F0F);

    // Randomized traffic with occasional key reloads
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 99) < 70);
      out_ready  = ($urandom_range(0, 99) < 60);
      in_data    = $urandom;
      rot_offset = 5'($urandom_range(0, 31));
      key_load   = ($urandom_range(0, 99) < 4);
      key_in     = $urandom;
      step();
    end
    key_load = 1'b0; out_ready = 1'b1;
    idle(8);

    // Reset with three words buffered
    out_ready = 1'b0;
    load_key(32'h3C3C3C3C);
    send($urandom, 5'd3); send($urandom, 5'd7); send($urandom, 5'd9);
    idle(2);
    check_eq("buffered3", 64'(fifo_count), 64'd3);
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_eq("async_out_valid", 64'(out_valid), 64'h0);
    check_eq("async_fifo_count", 64'(fifo_count), 64'h0);
    check_eq("async_out_data", 64'(out_data), 64'h0);
    check_eq("async_keyed", 64'(keyed), 64'h0);
    out_ready = 1'b1; in_valid = 1'b1;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    load_key(32'h00FF00FF);
    send(32'h0, 5'd8);
    idle(4);

    // Auto-rotation sequence
    if (AUTO) begin
      obs_log.delete();
      load_key(32'h00000001);
      for (int i = 0; i < 4; i++) send(32'h0, 5'd0);
      idle(4);
      check_eq("auto0", 64'(obs_log[0]), 64'h1);
      check_eq("auto1", 64'(obs_log[1]), 64'h2);
      check_eq("auto2", 64'(obs_log[2]), 64'h4);
      check_eq("auto3", 64'(obs_log[3]), 64'h8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rot_cipher_stream.md
ROT_CIPHER_STREAM -- requirements
Module: rot_cipher_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning plaintext/ciphertext word width (8..64).
REQ-002 SHALL have parameter KEY_W, default 32, meaning key width; KEY_W >= DATA_W, power of 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries; power of 2, >= 2.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: key_in  in  KEY_W  key value; key_load  in  1  one-cycle key program strobe.
REQ-006 SHALL have ports: in_data  in  DATA_W  plaintext; rot_offset  in  ROT_W (=clog2(KEY_W))  per-word key rotation; in_valid  in  1; in_ready  out  1.
REQ-007 SHALL have ports: out_data  out  DATA_W  ciphertext; out_valid  out  1; out_ready  in  1.
REQ-008 SHALL have ports: keyed  out  1  key programmed; fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries.

Function
REQ-009 SHALL implement FSM states NOKEY and RUN; NOKEY -> RUN on key_load; RUN stays RUN on further key_load; only reset returns to NOKEY.
REQ-010 SHALL assert keyed iff state is RUN.
REQ-011 SHALL accept a word on any rising edge where in_valid and in_ready are both high.
REQ-012 SHALL drive in_ready high only in RUN and when fifo_count plus words in flight is below FIFO_DEPTH; in_ready SHALL be combinational from registered state only.
REQ-013 SHALL latch rot_offset with the accepted word; stage 1 rotates key left by effective offset mod KEY_W; offset 0 leaves key unchanged.
REQ-014 SHALL, in stage 2, compute out word = in_data XOR rotated_key[DATA_W-1:0] and write it to the FIFO.
REQ-015 SHALL present a word accepted at edge N on out_data with out_valid high after edge N+2 when FIFO was empty; full throughput one word/cycle.
REQ-016 SHALL pop the FIFO on edges where out_valid and out_ready are high; out_data SHALL hold stable while out_valid high and out_ready low.
REQ-017 SHALL preserve word order; FIFO pointers wrap modulo FIFO_DEPTH; simultaneous push and pop at full or empty SHALL leave count unchanged and lose no data.
REQ-018 SHALL apply a key_load to words accepted on later edges only; a word accepted on the same edge as key_load, or already in flight, SHALL use the old key.
REQ-019 SHALL ignore in_valid in NOKEY (in_ready low, no word consumed).

Reset
REQ-020 SHALL, on reset low, asynchronously force: state NOKEY, key zero, FIFO and pipeline emptied, in_ready 0, out_valid 0, out_data 0, keyed 0, fifo_count 0, auto-rotation counter 0.
REQ-021 SHALL discard all in-flight and buffered words when reset asserts mid-operation; none SHALL appear after release.
REQ-022 SHALL resume accepting input only after reset deasserts and a new key_load.

Configuration
REQ-023 SHALL, with ROT_CIPHER_AUTO_ROT_EN defined, use effective offset = (rot_offset + word_counter) mod KEY_W, word_counter incrementing per accepted word, wrapping at KEY_W, cleared on key_load.
REQ-024 SHALL, without ROT_CIPHER_AUTO_ROT_EN, use effective offset = rot_offset and contain no word counter.

Structure
REQ-025 SHALL take FSM state enum, default widths and rotate-left function from shared package yoda_cipher_pkg.
REQ-026 SHALL implement the output buffer as sub-module cipher_fifo (parametrised width/depth, count output).

Verification
REQ-027 Key 0xDEADBEEF, offset 0, data 0x00000000 -> out_data 0xDEADBEEF two cycles after accept.
REQ-028 Key 0x80000001, offset 1, data 0xFFFFFFFF -> out_data 0xFFFFFFFC; offset 31 -> 0x3FFFFFFF.
REQ-029 Stream 6 words with out_ready low, FIFO_DEPTH 4 -> in_ready drops after 4 accepted; release out_ready -> all 6 emerge in order.
REQ-030 key_load 0x0F0F0F0F on same edge as accepting word under old key 0x11111111 -> that word uses 0x11111111, next uses 0x0F0F0F0F.
REQ-031 Reset pulsed with 3 words buffered -> out_valid 0, fifo_count 0 immediately; no output until new key_load and input.
REQ-032 AUTO_ROT_EN, key 0x00000001, rot_offset 0, four data 0 words -> outputs 0x1, 0x2, 0x4, 0x8.
